// File: rtl/mfp_irq_pkg.sv
//------------------------------------------------------------------------------
// Module  : mfp_irq_pkg
// Brief   : Shared defaults, constants and priority encoder for the IRQ router.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mfp_irq_pkg;

  localparam int IRQ_SRC_COUNT_DEF    = 8;
  localparam int IRQ_EIC_CHANNELS_DEF = 32;
  localparam int IRQ_SRC_EIC_BASE_DEF = 2;
  localparam int IRQ_TIMER_EIC_CH_DEF = 31;
  localparam int IRQ_TIMER_HW_DEF     = 5;

  localparam int IRQ_IPTI_OFFSET = 2;
  localparam int IRQ_SW_CHANNELS = 2;

  // Encoder is sized for the largest legal source count.
  localparam int IRQ_MAX_SRC = 24;
  localparam int IRQ_ID_W    = 5;

  // Returns {valid, index} of the highest-numbered set bit.
  function automatic logic [IRQ_ID_W:0] irq_prio_enc(input logic [IRQ_MAX_SRC-1:0] vec);
    logic [IRQ_ID_W:0] r;
    r = '0;
    for (int i = 0; i < IRQ_MAX_SRC; i++) begin
      if (vec[i]) r = {1'b1, IRQ_ID_W'(i)};
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mfp_irq_sync_edge.sv
//------------------------------------------------------------------------------
// Module  : mfp_irq_sync_edge
// Brief   : Per-source 2-flop synchroniser, optional edge detect and pending
//           latch (edge support present when MFP_IRQ_EDGE_EN is defined).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mfp_irq_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic edge_i,
  input  logic ack_i,
  output logic pending_o
);

  logic s1_q;
  logic s2_q;

`ifdef MFP_IRQ_EDGE_EN
  logic s3_q;
  logic lat_q;
  logic lat_d;

  // Leaving edge mode drops the latch; a fresh edge beats a same-cycle ack.
  always_comb begin
    lat_d = lat_q;
    if (!edge_i)              lat_d = 1'b0;
    else if (s2_q && !s3_q)   lat_d = 1'b1;
    else if (ack_i)           lat_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      lat_q <= 1'b0;
    end else begin
      s1_q  <= src_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      lat_q <= lat_d;
    end
  end

  assign pending_o = edge_i ? lat_q : s2_q;
`else
  logic w_unused_sense;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= src_i;
      s2_q <= s1_q;
    end
  end

  assign w_unused_sense = edge_i ^ ack_i;
  assign pending_o      = s2_q;
`endif

endmodule

`default_nettype wire

// File: rtl/mfp_irq_router.sv
//------------------------------------------------------------------------------
// Module  : mfp_irq_router
// Brief   : Peripheral interrupt router feeding the EIC vector, compatibility
//           SI_Int/SI_IPTI lines and a registered priority ID.
//           Edge sense/ack support is built when MFP_IRQ_EDGE_EN is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mfp_irq_router
  import mfp_irq_pkg::*;
#(
  parameter int SRC_COUNT    = IRQ_SRC_COUNT_DEF,
  parameter int EIC_CHANNELS = IRQ_EIC_CHANNELS_DEF,
  parameter int SRC_EIC_BASE = IRQ_SRC_EIC_BASE_DEF,
  parameter int TIMER_EIC_CH = IRQ_TIMER_EIC_CH_DEF,
  parameter int TIMER_HW     = IRQ_TIMER_HW_DEF
) (
  input  logic                    SI_ClkIn,
  input  logic                    SI_Reset,
  input  logic                    SI_EICPresent,
  input  logic                    SI_TimerInt,
  input  logic [1:0]              SI_SWInt,
  input  logic [7:0]              EIC_Interrupt,
  input  logic [SRC_COUNT-1:0]    irq_src,
  input  logic [SRC_COUNT-1:0]    irq_edge,
  input  logic [SRC_COUNT-1:0]    irq_mask,
  input  logic                    irq_ack,
  input  logic [((SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1)-1:0] irq_ack_id,
  output logic [EIC_CHANNELS-1:0] EIC_input,
  output logic [7:0]              SI_Int,
  output logic [2:0]              SI_IPTI,
  output logic [SRC_COUNT-1:0]    irq_pending,
  output logic                    irq_active,
  output logic [((SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1)-1:0] irq_id
);

  localparam int ID_W = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;

  logic [SRC_COUNT-1:0]   w_ack_hit;
  logic [SRC_COUNT-1:0]   w_eff;
  logic [IRQ_MAX_SRC-1:0] w_eff_ext;
  logic [IRQ_ID_W:0]      w_prio;
  logic [7:0]             w_compat_int;
  logic                   w_unused_prio;

  logic                   active_q;
  logic [ID_W-1:0]        id_q;

  for (genvar i = 0; i < SRC_COUNT; i++) begin : g_src
    assign w_ack_hit[i] = irq_ack && (irq_ack_id == ID_W'(i));

    mfp_irq_sync_edge u_sync (
      .clk_i     (SI_ClkIn),
      .rst_i     (SI_Reset),
      .src_i     (irq_src[i]),
      .edge_i    (irq_edge[i]),
      .ack_i     (w_ack_hit[i]),
      .pending_o (irq_pending[i])
    );
  end

  assign w_eff = irq_pending & irq_mask;

  always_comb begin
    EIC_input                                = '0;
    EIC_input[IRQ_SW_CHANNELS-1:0]           = SI_SWInt;
    EIC_input[TIMER_EIC_CH]                  = SI_TimerInt;
    EIC_input[SRC_EIC_BASE +: SRC_COUNT]     = w_eff;
  end

  // Only the six compatibility hardware lines can carry sources; the timer's line stays free.
  for (genvar k = 0; k < 8; k++) begin : g_compat
    if ((k < SRC_COUNT) && (k < 6) && (k != TIMER_HW)) begin : g_map
      assign w_compat_int[k] = w_eff[k];
    end else begin : g_zero
      assign w_compat_int[k] = 1'b0;
    end
  end

  assign SI_Int  = SI_EICPresent ? EIC_Interrupt : w_compat_int;
  assign SI_IPTI = SI_EICPresent ? 3'd0 : 3'(TIMER_HW + IRQ_IPTI_OFFSET);

  assign w_eff_ext     = IRQ_MAX_SRC'(w_eff);
  assign w_prio        = irq_prio_enc(w_eff_ext);
  assign w_unused_prio = ^w_prio;

  // ID holds its last value while nothing is requesting.
  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      active_q <= 1'b0;
      id_q     <= '0;
    end else begin
      active_q <= w_prio[IRQ_ID_W];
      if (w_prio[IRQ_ID_W]) id_q <= w_prio[ID_W-1:0];
    end
  end

  assign irq_active = active_q;
  assign irq_id     = id_q;

endmodule

`default_nettype wire

// File: tb/tb_mfp_irq_router.sv
//------------------------------------------------------------------------------
// Module  : tb_mfp_irq_router
// Brief   : Self-checking bench for mfp_irq_router against a behavioural model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mfp_irq_router;

`ifdef MFP_IRQ_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        eic_present;
  logic        timer;
  logic [1:0]  sw;
  logic [7:0]  eic_int;
  logic [7:0]  src;
  logic [7:0]  edge_m;
  logic [7:0]  mask;
  logic        ack;
  logic [2:0]  ack_id;
  logic [31:0] eic_input;
  logic [7:0]  si_int;
  logic [2:0]  ipti;
  logic [7:0]  pending;
  logic        active;
  logic [2:0]  id;

  mfp_irq_router dut (
    .SI_ClkIn      (clk),
    .SI_Reset      (rst),
    .SI_EICPresent (eic_present),
    .SI_TimerInt   (timer),
    .SI_SWInt      (sw),
    .EIC_Interrupt (eic_int),
    .irq_src       (src),
    .irq_edge      (edge_m),
    .irq_mask      (mask),
    .irq_ack       (ack),
    .irq_ack_id    (ack_id),
    .EIC_input     (eic_input),
    .SI_Int        (si_int),
    .SI_IPTI       (ipti),
    .irq_pending   (pending),
    .irq_active    (active),
    .irq_id        (id)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: irq_src as sampled 1, 2 and 3 clock edges ago, latched edge events, priority regs.
  logic [7:0] smp1, smp2, smp3;
  logic [7:0] m_lat;
  logic       m_active;
  logic [2:0] m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] model_pend();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = (EDGE_EN && edge_m[i]) ? m_lat[i] : smp2[i];
    return p;
  endfunction

  function automatic logic [2:0] top_idx(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_reset();
    smp1 = '0; smp2 = '0; smp3 = '0; m_lat = '0; m_active = 1'b0; m_id = '0;
  endtask

  task automatic model_edge();
    logic [7:0] eff;
    eff = model_pend() & mask;
    m_active = (eff != 0);
    if (eff != 0) m_id = top_idx(eff);
    for (int i = 0; i < 8; i++) begin
      if (EDGE_EN && edge_m[i]) begin
        if (smp2[i] && !smp3[i])            m_lat[i] = 1'b1;
        else if (ack && ack_id == 3'(i))    m_lat[i] = 1'b0;
      end else begin
        m_lat[i] = 1'b0;
      end
    end
    smp3 = smp2; smp2 = smp1; smp1 = src;
  endtask

  task automatic check_all();
    logic [7:0]  p, eff, exp_si;
    logic [31:0] exp_eic;
    p   = model_pend();
    eff = p & mask;
    exp_eic       = '0;
    exp_eic[1:0]  = sw;
    exp_eic[31]   = timer;
    exp_eic[9:2]  = eff;
    exp_si = eic_present ? eic_int : {3'b000, eff[4:0]};
    chk("pending",   32'(pending), 32'(p));
    chk("eic_input", eic_input,    exp_eic);
    chk("si_int",    32'(si_int),  32'(exp_si));
    chk("si_ipti",   32'(ipti),    eic_present ? 32'd0 : 32'd7);
    chk("active",    32'(active),  32'(m_active));
    chk("id",        32'(id),      32'(m_id));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; eic_present = 1'b0; timer = 1'b0; sw = '0; eic_int = '0;
    src = '0; edge_m = '0; mask = '0; ack = 1'b0; ack_id = '0;
    model_reset();
    #2;
    check_all();
    step(); step();
    rst = 1'b0;

    // Edge latch and acknowledge on source 3.
    edge_m = 8'hFF; mask = 8'hFF; src = 8'h08;
    step(); step();
    src = 8'h00;
    step();
    if (EDGE_EN) chk("edge3_pending", 32'(pending), 32'h08);
    step();
    if (EDGE_EN) chk("edge3_id", 32'(id), 32'd3);
    ack = 1'b1; ack_id = 3'd3;
    step();
    ack = 1'b0;
    if (EDGE_EN) chk("edge3_acked", 32'(pending), 32'h00);
    step(); step();

    // Priority across sources 1, 4, 6 then ack down the list.
    src = 8'h52; step(); step();
    src = 8'h00; step(); step();
    if (EDGE_EN) chk("prio_id6", 32'(id), 32'd6);
    foreach (ack_id[j]) ;
    for (int k = 0; k < 3; k++) begin
      ack = 1'b1; ack_id = (k == 0) ? 3'd6 : (k == 1) ? 3'd4 : 3'd1;
      step();
      ack = 1'b0;
      step();
    end
    if (EDGE_EN) chk("prio_drained", 32'(active), 32'd0);

    // Set/clear collision on source 2.
    src = 8'h04; step(); step();
    src = 8'h00; step(); step(); step();
    src = 8'h04; step(); step();
    ack = 1'b1; ack_id = 3'd2;
    step();
    ack = 1'b0;
    if (EDGE_EN) chk("collide_pend2", 32'(pending[2]), 32'd1);
    src = 8'h00; ack = 1'b1; step(); ack = 1'b0; step();

    // Level follow on source 0 with ignored ack.
    edge_m = 8'h00; src = 8'h01;
    for (int k = 0; k < 10; k++) begin
      ack = k[0]; ack_id = 3'd0;
      step();
    end
    ack = 1'b0; src = 8'h00;
    step(); step(); step();

    // Mode switch.
    eic_present = 1'b1; eic_int = 8'hA5;
    step();
    chk("eic_si_int", 32'(si_int), 32'hA5);
    chk("eic_ipti",   32'(ipti),   32'd0);
    eic_present = 1'b0; src = 8'h20;
    step(); step(); step();
    chk("compat_ipti",  32'(ipti),      32'd7);
    chk("compat_bit5",  32'(si_int[5]), 32'd0);
    chk("compat_pend5", 32'(pending[5]), 32'd1);

    // Asynchronous reset with several sources pending.
    src = 8'h07; step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_pending", 32'(pending), 32'd0);
    chk("arst_active",  32'(active),  32'd0);
    chk("arst_id",      32'(id),      32'd0);
    check_all();
    step();
    rst = 1'b0;

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      src     = 8'($urandom);
      timer   = 1'($urandom);
      sw      = 2'($urandom);
      eic_int = 8'($urandom);
      mask    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      ack     = ($urandom_range(0, 3) == 0);
      ack_id  = 3'($urandom);
      if ($urandom_range(0, 39) == 0) edge_m = 8'($urandom);
      if ($urandom_range(0, 49) == 0) eic_present = ~eic_present;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mfp_irq_router.md
# mfp_irq_router

Parametrised interrupt router that replaces the fixed-wiring interrupt map in `mfp_system`. It takes `SRC_COUNT` asynchronous peripheral interrupt lines and passes each through a 2-flop synchroniser. Each source has a per-source level/edge sense mode, a latched pending bit for edge sources with explicit acknowledge, and a mask. It then drives both the external interrupt controller (EIC) input vector and the MIPS compatibility-mode `SI_Int`/`SI_IPTI` lines, plus a registered highest-priority source ID for software polling.

## Interface
- `SRC_COUNT`, 8: number of peripheral sources, 1..24.
- `EIC_CHANNELS`, 32: width of the EIC input vector.
- `SRC_EIC_BASE`, 2: EIC channel of source 0; source i drives channel `SRC_EIC_BASE+i`. Requires `SRC_EIC_BASE+SRC_COUNT <= EIC_CHANNELS`.
- `TIMER_EIC_CH`, 31: EIC channel for `SI_TimerInt`. Must lie outside the source range and outside channels 0..1.
- `TIMER_HW`, 5: compatibility-mode hardware line used for the timer, 0..5.

Ports:
- `SI_ClkIn`, in, 1: system clock.
- `SI_Reset`, in, 1: asynchronous, active-high reset.
- `SI_EICPresent`, in, 1: 1 selects EIC mode, 0 selects compatibility mode; quasi-static.
- `SI_TimerInt`, in, 1: core timer interrupt, synchronous to `SI_ClkIn`.
- `SI_SWInt`, in, 2: core software interrupts.
- `EIC_Interrupt`, in, 8: request from the EIC, passed through in EIC mode.
- `irq_src`, in, `SRC_COUNT`: asynchronous peripheral interrupt lines, active-high.
- `irq_edge`, in, `SRC_COUNT`: per-source sense, 1 = rising edge, 0 = level; quasi-static.
- `irq_mask`, in, `SRC_COUNT`: per-source enable, 1 = enabled.
- `irq_ack`, in, 1: single-cycle acknowledge strobe.
- `irq_ack_id`, in, `$clog2(SRC_COUNT)`: source cleared by `irq_ack`.
- `EIC_input`, out, `EIC_CHANNELS`: EIC request vector.
- `SI_Int`, out, 8: core hardware interrupt lines.
- `SI_IPTI`, out, 3: timer interrupt line select.
- `irq_pending`, out, `SRC_COUNT`: raw pending bits, before masking.
- `irq_active`, out, 1: registered; 1 when any source is both pending and enabled.
- `irq_id`, out, `$clog2(SRC_COUNT)`: registered index of the highest-numbered source that is pending and enabled.

## Operation
- **Synchroniser.** Per source: `s1 <= irq_src[i]`, `s2 <= s1`, `s3 <= s2`.
- **Level source.** `pending[i] = s2`. Level sources do not latch and ignore `irq_ack`.
- **Edge source, set.** `pending[i]` is set when `s2 & ~s3`.
- **Edge source, clear.** `pending[i]` is cleared when `irq_ack && irq_ack_id == i`.
- **Simultaneous set and clear.** Set wins; the bit stays 1.
- **Ack to out-of-range or level source.** `irq_ack` with `irq_ack_id >= SRC_COUNT`, or naming a level source, has no effect.
- **Masking.** `eff = pending & irq_mask`. The mask gates outputs only; masked edge events still latch.
- **`EIC_input` composition.**
  - Bits 1:0 = `SI_SWInt`.
  - Bit `TIMER_EIC_CH` = `SI_TimerInt`.
  - Bits `[SRC_EIC_BASE +: SRC_COUNT]` = `eff`.
  - All other bits 0.
  - The whole vector is combinational, independent of `SI_EICPresent`.
- **Compatibility mode (`SI_EICPresent` = 0).**
  - `SI_Int[k] = eff[k]` for `k < min(SRC_COUNT, 6)` and `k != TIMER_HW`.
  - All other `SI_Int` bits are 0.
  - `SI_IPTI = TIMER_HW + 2`.
- **EIC mode (`SI_EICPresent` = 1).** `SI_Int = EIC_Interrupt` and `SI_IPTI = 0`. Both are combinational.
- **Priority.** `irq_id` and `irq_active` register the highest-index set bit of `eff` each cycle. When `eff` is 0: `irq_active` = 0 and `irq_id` holds its last value.
- **Sense change.** Changing `irq_edge[i]` from 1 to 0 discards the latched bit; pending then follows `s2`.

## Timing
- **Reset values.**
  - Cleared asynchronously by `SI_Reset`: `s1`, `s2`, `s3`, edge-pending bits, `irq_active`, `irq_id`.
  - Consequently 0 during reset: `irq_pending`, the source bits of `EIC_input`, `SI_Int` in compatibility mode.
  - `SI_IPTI` follows `SI_EICPresent` during reset.
- **Source latency.** `irq_src` stable before edge N gives `irq_pending` and `EIC_input`/`SI_Int` high after edge N+2, and `irq_active`/`irq_id` after edge N+3.
- **Ack latency.** An `irq_ack` sampled at edge M clears pending after edge M; `irq_active` drops after edge M+1 if nothing else is pending.
- **Pulse width.** Minimum detectable source pulse is one clock period plus setup/hold.
- **Timer and software paths.** `SI_TimerInt` and `SI_SWInt` are same-clock signals with zero latency (combinational).
- **Reset mid-operation.** Loses all latched events; there is no replay.

## Configuration
- Macro: `MFP_IRQ_EDGE_EN`.
- **Defined.** Per-source edge sense, `s3`, edge-pending flops and acknowledge logic are all present, as described above.
- **Undefined.** All sources are level; `irq_edge`, `irq_ack` and `irq_ack_id` are ignored; no `s3` or latch flops; `pending = s2`. All other behaviour and ports are unchanged.

## Structure
- **Package `mfp_irq_pkg`:**
  - default parameter values;
  - `IRQ_IPTI_OFFSET` = 2;
  - `IRQ_SW_CHANNELS` = 2;
  - a function `irq_prio_enc(vec)` returning `{valid, index}`.
- **Sub-module `mfp_irq_sync_edge`:** one instance per source; contains the synchroniser, edge detect and pending latch, plus the sense and ack inputs.
- **Top level:** mapping, masking and the priority register.

## Test plan
- **Edge latch and ack.** Source 3 in edge mode, mask all: pulse `irq_src[3]` for 2 cycles → `irq_pending` = 0x08 after 3 edges, `EIC_input[5]` = 1, `irq_id` = 3. Ack id 3 → pending clears next edge.
- **Level follow.** Source 0 in level mode: hold high 10 cycles then low → `SI_Int[0]` high for exactly 10 cycles delayed by 2; ack ignored.
- **Priority.** Edge events on sources 1, 4 and 6 → `irq_id` = 6; ack 6 → `irq_id` = 4; ack 4 → `irq_id` = 1; ack 1 → `irq_active` = 0.
- **Set/clear collision.** New edge on source 2 in the same cycle as its ack → `pending[2]` stays 1.
- **Mode switch.**
  - `SI_EICPresent` = 1, `EIC_Interrupt` = 0xA5 → `SI_Int` = 0xA5, `SI_IPTI` = 0.
  - `SI_EICPresent` = 0 → `SI_IPTI` = 7, `SI_Int[5]` = 0 even when source 5 is pending.
- **Async reset mid-operation.** Pulse `SI_Reset` with 3 sources pending → all pending bits, `irq_active` and `irq_id` are 0 immediately, before any clock edge.
